// File: rtl/stage1_dict_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage1_pkg
// Description : Shared types for the stage-1 dictionary controller:
//               record code types, controller FSM states and the mapping
//               from comparator match level to record code.
// Revision    : 1.0 - initial release
// ============================================================================
package stage1_pkg;

    typedef enum logic [2:0] {
        CODE_ZERO    = 3'd0,
        CODE_MISS    = 3'd1,
        CODE_MATCH16 = 3'd2,
        CODE_MATCH24 = 3'd3,
        CODE_FULL    = 3'd4
    } code_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Comparator level 00/01/10/11 -> MISS/MATCH16/MATCH24/FULL
    function automatic code_t type_to_code(input logic [1:0] type_matched);
        case (type_matched)
            2'b00:   return CODE_MISS;
            2'b01:   return CODE_MATCH16;
            2'b10:   return CODE_MATCH24;
            default: return CODE_FULL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage1_dict_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : stage1_dict_ctrl_if
// Description : Word-in / record-out handshake bundle of the stage-1
//               dictionary controller.
//               Word side   : i_valid, i_word, i_last -> o_ready
//               Record side : o_valid, o_code, o_location, o_word, o_last
//                             <- i_ready
//               slave modport = controller, master modport = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface stage1_dict_ctrl_if #(
    parameter int INPUT_WORD = 32,
    parameter int DICT_ENTRY = 16
);
    localparam int LOC_W = $clog2(DICT_ENTRY);

    logic                  i_valid;
    logic [INPUT_WORD-1:0] i_word;
    logic                  i_last;
    logic                  o_ready;
    logic                  o_valid;
    logic [2:0]            o_code;
    logic [LOC_W-1:0]      o_location;
    logic [INPUT_WORD-1:0] o_word;
    logic                  o_last;
    logic                  i_ready;

    modport slave (
        input  i_valid, i_word, i_last, i_ready,
        output o_ready, o_valid, o_code, o_location, o_word, o_last
    );

    modport master (
        output i_valid, i_word, i_last, i_ready,
        input  o_ready, o_valid, o_code, o_location, o_word, o_last
    );
endinterface
`default_nettype wire

// File: rtl/stage1_dict_ctrl_comparator_array2.sv
`default_nettype none
// ============================================================================
// Module      : comparator_array2
// Description : Compares one word against every dictionary entry and reports
//               the best prefix match level and its index.
//               word         in  word under compare
//               dict         in  flattened dictionary, entry k at
//                                [k*DICT_WORD +: DICT_WORD]
//               type_matched out 00 none, 01 upper 16, 10 upper 24, 11 full
//               location     out index of the best entry
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_array2 #(
    parameter int DICT_ENTRY = 16,
    parameter int DICT_WORD  = 32,
    parameter int LOC_W      = $clog2(DICT_ENTRY)
) (
    input  wire logic [DICT_WORD-1:0]            word,
    input  wire logic [DICT_ENTRY*DICT_WORD-1:0] dict,
    output logic      [1:0]                      type_matched,
    output logic      [LOC_W-1:0]                location
);

    function automatic logic [1:0] entry_level(input logic [DICT_WORD-1:0] a,
                                               input logic [DICT_WORD-1:0] b);
        if (a == b)                                    return 2'b11;
        else if (a[DICT_WORD-1 -: 24] == b[DICT_WORD-1 -: 24]) return 2'b10;
        else if (a[DICT_WORD-1 -: 16] == b[DICT_WORD-1 -: 16]) return 2'b01;
        else                                           return 2'b00;
    endfunction

    logic [1:0] w_lvl;

    // Strict '>' keeps the lowest index among equally good entries.
    always_comb begin
        type_matched = 2'b00;
        location     = '0;
        w_lvl        = 2'b00;
        for (int k = 0; k < DICT_ENTRY; k++) begin
            w_lvl = entry_level(word, dict[k*DICT_WORD +: DICT_WORD]);
            if (w_lvl > type_matched) begin
                type_matched = w_lvl;
                location     = LOC_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage1_dict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stage1_dict_ctrl
// Description : Stage-1 compression controller. Accepts words, compares each
//               against a FIFO-replacement dictionary, emits one code record
//               per word and pushes non-FULL/non-ZERO words into the
//               dictionary.
//               i_clk    in  clock, rising edge
//               i_rst_n  in  asynchronous active-low reset
//               i_clear  in  synchronous dictionary clear / abort
//               bus      slave handshake bundle (stage1_dict_ctrl_if)
//               Optional feature macro: STAGE1_ZERO_DETECT_EN (zero words
//               produce code ZERO without a dictionary push).
// Revision    : 1.0 - initial release
// ============================================================================
module stage1_dict_ctrl
    import stage1_pkg::*;
#(
    parameter int INPUT_WORD = 32,
    parameter int DICT_ENTRY = 16,
    parameter int DICT_WORD  = 32
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    input  wire logic           i_clear,
    stage1_dict_ctrl_if.slave   bus
);

    localparam int LOC_W = $clog2(DICT_ENTRY);

    state_t                          r_state, w_next;
    logic [INPUT_WORD-1:0]           r_word;
    logic                            r_last_in;
    code_t                           r_code;
    logic [LOC_W-1:0]                r_loc;
    logic [INPUT_WORD-1:0]           r_out_word;
    logic                            r_out_last;
    logic [DICT_WORD-1:0]            r_dict_mem [DICT_ENTRY];
    logic [LOC_W-1:0]                r_wr_ptr;
    logic [DICT_ENTRY*DICT_WORD-1:0] w_dict_flat;

    logic                            w_load, w_cmp, w_dict_clear, w_ready, w_valid;
    logic [1:0]                      w_type;
    logic [LOC_W-1:0]                w_cmp_loc;
    code_t                           w_code;
    logic [LOC_W-1:0]                w_loc;
    logic                            w_push;

    for (genvar k = 0; k < DICT_ENTRY; k++) begin : g_flat
        assign w_dict_flat[k*DICT_WORD +: DICT_WORD] = r_dict_mem[k];
    end

    comparator_array2 #(
        .DICT_ENTRY (DICT_ENTRY),
        .DICT_WORD  (DICT_WORD),
        .LOC_W      (LOC_W)
    ) u_cmp (
        .word         (r_word),
        .dict         (w_dict_flat),
        .type_matched (w_type),
        .location     (w_cmp_loc)
    );

    // Record code for the registered word
    always_comb begin
        w_code = type_to_code(w_type);
        w_loc  = (w_code == CODE_MISS) ? '0 : w_cmp_loc;
`ifdef STAGE1_ZERO_DETECT_EN
        if (r_word == '0) begin
            w_code = CODE_ZERO;
            w_loc  = '0;
        end
`endif
        w_push = (w_code == CODE_MISS) || (w_code == CODE_MATCH16) ||
                 (w_code == CODE_MATCH24);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_cmp        = 1'b0;
        w_dict_clear = 1'b0;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_valid) begin
                    w_load = 1'b1;
                    w_next = S_CMP;
                end
            end
            S_CMP: begin
                w_cmp  = 1'b1;
                w_next = S_OUT;
            end
            S_OUT: begin
                w_valid = 1'b1;
                // A last record ends the block, so no new word rides on it.
                w_ready = bus.i_ready && !r_out_last;
                if (bus.i_ready) begin
                    if (r_out_last) begin
                        w_dict_clear = 1'b1;
                        w_next       = S_IDLE;
                    end else if (bus.i_valid) begin
                        w_load = 1'b1;
                        w_next = S_CMP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Clear wins over any handshake in the same cycle
        if (i_clear) begin
            w_next       = S_IDLE;
            w_ready      = 1'b0;
            w_load       = 1'b0;
            w_cmp        = 1'b0;
            w_dict_clear = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word     <= '0;
            r_last_in  <= 1'b0;
            r_code     <= CODE_ZERO;
            r_loc      <= '0;
            r_out_word <= '0;
            r_out_last <= 1'b0;
            r_wr_ptr   <= '0;
            for (int k = 0; k < DICT_ENTRY; k++) r_dict_mem[k] <= '0;
        end else begin
            if (w_load) begin
                r_word    <= bus.i_word;
                r_last_in <= bus.i_last;
            end
            if (w_cmp) begin
                r_code     <= w_code;
                r_loc      <= w_loc;
                r_out_word <= r_word;
                r_out_last <= r_last_in;
            end
            if (w_dict_clear) begin
                r_wr_ptr <= '0;
                for (int k = 0; k < DICT_ENTRY; k++) r_dict_mem[k] <= '0;
            end else if (w_cmp && w_push) begin
                r_dict_mem[r_wr_ptr] <= r_word;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
        end
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_valid    = w_valid;
    assign bus.o_code     = r_code;
    assign bus.o_location = r_loc;
    assign bus.o_word     = r_out_word;
    assign bus.o_last     = r_out_last;

endmodule
`default_nettype wire
